// File: rtl/framebuffer_arbiter.sv
// Shares one pixel RAM: display reads win, host writes fill the back bank. Bank flips wait for frame_start.
// Reads return 3 cycles after rd_req. Host writes are held off by wr_ready during reads or while a flip is pending.
module framebuffer_arbiter #(
    parameter int PIXEL_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH       = 18,
    parameter int STALL_CNT_WIDTH  = 16
) (
    input  logic                        clk_in,
    input  logic                        reset,
    input  logic                        rd_req,
    input  logic [PIXEL_ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [PIXEL_ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        swap_req,
    input  logic                        frame_start,
    output logic                        swap_pending,
    output logic                        display_bank,
    output logic [PIXEL_ADDR_WIDTH:0]   ram_addr,
    output logic                        ram_we,
    output logic [DATA_WIDTH-1:0]       ram_wdata,
    input  logic [DATA_WIDTH-1:0]       ram_rdata,
    output logic [STALL_CNT_WIDTH-1:0]  wr_stall_cycles
);

    typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} swap_state_t;

    swap_state_t                 r_state;
    swap_state_t                 w_state_nxt;
    logic                        w_flip;
    logic                        w_swap_pending;
    logic                        w_wr_ready;
    logic                        w_wr_issue;
    logic                        r_display_bank;
    logic [PIXEL_ADDR_WIDTH:0]   r_ram_addr;
    logic                        r_ram_we;
    logic [DATA_WIDTH-1:0]       r_ram_wdata;
    logic                        r_rd_p1;
    logic                        r_rd_p2;
    logic                        r_rd_valid;
    logic [DATA_WIDTH-1:0]       r_rd_data;
    logic [STALL_CNT_WIDTH-1:0]  r_stall;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A swap_req coinciding with frame_start flips immediately and never enters PENDING.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (swap_req && !frame_start) w_state_nxt = S_PENDING;
            S_PENDING: if (frame_start) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_swap_pending = 1'b0;
        w_flip         = 1'b0;
        case (r_state)
            S_IDLE:    w_flip = swap_req && frame_start;
            S_PENDING: begin
                w_swap_pending = 1'b1;
                w_flip         = frame_start;
            end
            default:   w_flip = 1'b0;
        endcase
    end

    assign w_wr_ready = !reset && !rd_req && !w_swap_pending;
    assign w_wr_issue = wr_valid && w_wr_ready;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_display_bank <= 1'b0;
        end else if (w_flip) begin
            r_display_bank <= ~r_display_bank;
        end
    end

    // The bank bit is captured with the request, so a same-edge flip cannot retarget it.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_rd_p1     <= 1'b0;
        end else begin
            r_ram_we <= w_wr_issue;
            r_rd_p1  <= rd_req;
            if (rd_req) begin
                r_ram_addr <= {r_display_bank, rd_addr};
            end else if (w_wr_issue) begin
                r_ram_addr  <= {~r_display_bank, wr_addr};
                r_ram_wdata <= wr_data;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_rd_p2    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_p2    <= r_rd_p1;
            r_rd_valid <= r_rd_p2;
            if (r_rd_p2) begin
                r_rd_data <= ram_rdata;
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_stall <= '0;
        end else if (wr_valid && !w_wr_ready && (r_stall != '1)) begin
            r_stall <= r_stall + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign rd_data         = r_rd_data;
    assign rd_valid        = r_rd_valid;
    assign wr_ready        = w_wr_ready;
    assign swap_pending    = w_swap_pending;
    assign display_bank    = r_display_bank;
    assign ram_addr        = r_ram_addr;
    assign ram_we          = r_ram_we;
    assign ram_wdata       = r_ram_wdata;
    assign wr_stall_cycles = r_stall;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (ordered memory image, expected-read queue, swap rules).
module tb_framebuffer_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 18;
    localparam int SW    = 7;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int DEPTH = 1 << (AW + 1);

    logic          clk_in = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          swap_req;
    logic          frame_start;
    logic          swap_pending;
    logic          display_bank;
    logic [AW:0]   ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [SW-1:0] wr_stall_cycles;

    framebuffer_arbiter #(
        .PIXEL_ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .STALL_CNT_WIDTH(SW)
    ) dut (
        .clk_in(clk_in), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .frame_start(frame_start),
        .swap_pending(swap_pending), .display_bank(display_bank),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_stall_cycles(wr_stall_cycles)
    );

    always #5 clk_in = ~clk_in;

    // Single-port synchronous-read RAM attached to the arbiter.
    logic [DW-1:0] env_mem [0:DEPTH-1];
    always @(posedge clk_in) begin
        if (ram_we) env_mem[ram_addr] <= ram_wdata;
        ram_rdata <= env_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic [DW-1:0] dat;
    } rd_exp_t;

    logic [DW-1:0] m_mem [0:DEPTH-1];
    rd_exp_t       exp_q[$];
    logic          m_bank;
    logic          m_pend;
    int            m_stall;
    logic [AW:0]   m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic          m_wr_ready;

    int vectors     = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        m_bank  = 1'b0;
        m_pend  = 1'b0;
        m_stall = 0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_wdata = '0;
        exp_q.delete();
    endtask

    // Applies the arbitration and swap rules to the current cycle's inputs.
    task automatic model_step();
        m_wr_ready = !rd_req && !m_pend;
        m_we       = 1'b0;
        if (rd_req) begin
            m_addr = {m_bank, rd_addr};
            exp_q.push_back('{due: cyc + 3, dat: m_mem[{m_bank, rd_addr}]});
        end else if (wr_valid && m_wr_ready) begin
            m_addr  = {~m_bank, wr_addr};
            m_we    = 1'b1;
            m_wdata = wr_data;
            m_mem[{~m_bank, wr_addr}] = wr_data;
        end
        if (wr_valid && !m_wr_ready && m_stall != SMAX) m_stall++;
        if (!m_pend) begin
            if (swap_req && frame_start) m_bank = ~m_bank;
            else if (swap_req)           m_pend = 1'b1;
        end else if (frame_start) begin
            m_bank = ~m_bank;
            m_pend = 1'b0;
        end
    endtask

    task automatic drive(input logic rd, input logic [AW-1:0] ra, input logic wv,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic sw, input logic fs);
        rd_req = rd; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
        swap_req = sw; frame_start = fs;
        #1;
        model_step();
    endtask

    task automatic set_idle();
        rd_req = 1'b0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        swap_req = 1'b0; frame_start = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        set_idle();
        wr_valid = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        vectors++;
        if (rd_valid !== 1'b0 || rd_data !== '0)
            begin miscompares++; $display("FAIL reset_rd: rd_valid=%0b rd_data=%h want 0/0", rd_valid, rd_data); end
        vectors++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0)
            begin miscompares++; $display("FAIL reset_ram: we=%0b addr=%h wdata=%h want 0/0/0", ram_we, ram_addr, ram_wdata); end
        vectors++;
        if (display_bank !== 1'b0 || swap_pending !== 1'b0)
            begin miscompares++; $display("FAIL reset_swap: bank=%0b pending=%0b want 0/0", display_bank, swap_pending); end
        vectors++;
        if (wr_ready !== 1'b0 || wr_stall_cycles !== '0)
            begin miscompares++; $display("FAIL reset_wr: wr_ready=%0b stall=%0d want 0/0", wr_ready, wr_stall_cycles); end
        reset = 1'b0;
        set_idle();
        model_reset();
    endtask

    task automatic test_read_burst();
        bit exp_v;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1'b1, AW'(5 + i), 1'b0, '0, '0, 1'b0, 1'b0);
            else       drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
            if (i < 3) begin
                vectors++;
                if (ram_addr !== (AW+1)'(5 + i))
                    begin miscompares++; $display("FAIL burst_addr[%0d]: got %h want %h", i, ram_addr, 5 + i); end
            end
            exp_v = (i >= 2 && i <= 4);
            vectors++;
            if (rd_valid !== exp_v)
                begin miscompares++; $display("FAIL burst_valid[%0d]: got %0b want %0b", i, rd_valid, exp_v); end
            if (exp_v) begin
                vectors++;
                if (rd_data !== DW'(i + 3))
                    begin miscompares++; $display("FAIL burst_data[%0d]: got %h want %h", i, rd_data, i + 3); end
            end
        end
    endtask

    task automatic test_write_stall();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, AW'(i), 1'b1, AW'(10'h3FF), DW'(18'h2AAAA), 1'b0, 1'b0);
            vectors++;
            if (wr_ready !== 1'b0)
                begin miscompares++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, wr_ready); end
            tick();
        end
        drive(1'b0, '0, 1'b1, AW'(10'h3FF), DW'(18'h2AAAA), 1'b0, 1'b0);
        vectors++;
        if (wr_ready !== 1'b1)
            begin miscompares++; $display("FAIL free_ready: got %0b want 1", wr_ready); end
        tick();
        vectors++;
        if (ram_we !== 1'b1 || ram_addr !== 11'h7FF || ram_wdata !== 18'h2AAAA)
            begin miscompares++; $display("FAIL write_land: we=%0b addr=%h data=%h want 1/7ff/2aaaa", ram_we, ram_addr, ram_wdata); end
        vectors++;
        if (wr_stall_cycles !== SW'(64))
            begin miscompares++; $display("FAIL stall_count: got %0d want 64", wr_stall_cycles); end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (ram_we !== 1'b0)
            begin miscompares++; $display("FAIL write_pulse: we=%0b want 0", ram_we); end
    endtask

    task automatic test_swap();
        do_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, '0, 1'b1, AW'(i), DW'(i), 1'b0, 1'b0);
            vectors++;
            if (wr_ready !== 1'b0 || swap_pending !== 1'b1 || display_bank !== 1'b0)
                begin miscompares++; $display("FAIL swap_wait[%0d]: ready=%0b pending=%0b bank=%0b want 0/1/0", i, wr_ready, swap_pending, display_bank); end
            tick();
        end
        drive(1'b0, '0, 1'b1, '0, '0, 1'b0, 1'b1);
        tick();
        vectors++;
        if (swap_pending !== 1'b0 || display_bank !== 1'b1)
            begin miscompares++; $display("FAIL swap_flip: pending=%0b bank=%0b want 0/1", swap_pending, display_bank); end
        drive(1'b1, AW'(9), 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (ram_addr !== 11'h409)
            begin miscompares++; $display("FAIL swap_read_addr: got %h want 409", ram_addr); end
    endtask

    task automatic test_swap_same_cycle();
        do_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b1);
        tick();
        vectors++;
        if (display_bank !== 1'b1 || swap_pending !== 1'b0)
            begin miscompares++; $display("FAIL same_cycle_flip: bank=%0b pending=%0b want 1/0", display_bank, swap_pending); end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (display_bank !== 1'b1 || swap_pending !== 1'b0)
            begin miscompares++; $display("FAIL same_cycle_after: bank=%0b pending=%0b want 1/0", display_bank, swap_pending); end
    endtask

    task automatic test_read_at_flip();
        do_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, AW'(3), 1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        vectors++;
        if (ram_addr !== 11'h003 || display_bank !== 1'b1)
            begin miscompares++; $display("FAIL flip_old_bank: addr=%h bank=%0b want 003/1", ram_addr, display_bank); end
        drive(1'b1, AW'(3), 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (ram_addr !== 11'h403)
            begin miscompares++; $display("FAIL flip_new_bank: addr=%h want 403", ram_addr); end
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== DW'(18'h003))
            begin miscompares++; $display("FAIL flip_old_data: valid=%0b data=%h want 1/003", rd_valid, rd_data); end
        tick();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== DW'(18'h403))
            begin miscompares++; $display("FAIL flip_new_data: valid=%0b data=%h want 1/403", rd_valid, rd_data); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        drive(1'b1, AW'(1), 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, AW'(2), 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (swap_pending !== 1'b1)
            begin miscompares++; $display("FAIL inflight_pending: got %0b want 1", swap_pending); end
        set_idle();
        reset = 1'b1;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || swap_pending !== 1'b0 || display_bank !== 1'b0 || ram_addr !== '0 || ram_we !== 1'b0 || wr_ready !== 1'b0)
            begin miscompares++; $display("FAIL inflight_async: valid=%0b pend=%0b bank=%0b addr=%h we=%0b ready=%0b want all 0", rd_valid, swap_pending, display_bank, ram_addr, ram_we, wr_ready); end
        tick();
        tick();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
            tick();
            vectors++;
            if (rd_valid !== 1'b0 || rd_data !== '0 || swap_pending !== 1'b0 || display_bank !== 1'b0)
                begin miscompares++; $display("FAIL inflight_after[%0d]: valid=%0b data=%h pend=%0b bank=%0b want 0", i, rd_valid, rd_data, swap_pending, display_bank); end
        end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 150; i++) begin
            drive(1'b0, '0, 1'b1, AW'(i), DW'(i), 1'b0, 1'b0);
            tick();
            if (i == 99) begin
                vectors++;
                if (wr_stall_cycles !== SW'(100))
                    begin miscompares++; $display("FAIL stall_mid: got %0d want 100", wr_stall_cycles); end
            end
        end
        vectors++;
        if (wr_stall_cycles !== SW'(SMAX))
            begin miscompares++; $display("FAIL stall_sat: got %0d want %0d", wr_stall_cycles, SMAX); end
    endtask

    task automatic test_random();
        bit exp_v;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 45, AW'($urandom), $urandom_range(0, 99) < 60,
                  AW'($urandom), DW'($urandom), $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 5);
            vectors++;
            if (wr_ready !== m_wr_ready)
                begin miscompares++; $display("FAIL rnd_ready[%0d]: got %0b want %0b", i, wr_ready, m_wr_ready); end
            tick();
            vectors++;
            if (ram_we !== m_we || ram_addr !== m_addr || (m_we && ram_wdata !== m_wdata))
                begin miscompares++; $display("FAIL rnd_port[%0d]: we=%0b addr=%h data=%h want %0b/%h/%h", i, ram_we, ram_addr, ram_wdata, m_we, m_addr, m_wdata); end
            vectors++;
            if (display_bank !== m_bank || swap_pending !== m_pend)
                begin miscompares++; $display("FAIL rnd_swap[%0d]: bank=%0b pend=%0b want %0b/%0b", i, display_bank, swap_pending, m_bank, m_pend); end
            vectors++;
            if (wr_stall_cycles !== SW'(m_stall))
                begin miscompares++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, wr_stall_cycles, m_stall); end
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            vectors++;
            if (rd_valid !== exp_v || (exp_v && rd_data !== exp_q[0].dat))
                begin miscompares++; $display("FAIL rnd_read[%0d]: valid=%0b data=%h want %0b/%h", i, rd_valid, rd_data, exp_v, exp_v ? exp_q[0].dat : '0); end
            if (exp_v) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = DW'(i);
            m_mem[i]   = DW'(i);
        end
        set_idle();
        reset = 1'b1;
        model_reset();
        test_reset();
        test_read_burst();
        test_write_stall();
        test_swap();
        test_swap_same_cycle();
        test_read_at_flip();
        test_reset_inflight();
        test_stall_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
